// File: rtl/register_file_arbiter.sv
// Round-robin arbiter sharing one register-file port between the UART command path (0) and ALU fetch path (1).
// Latency: req to ack 1 cycle; writes every 2 cycles; rd_valid 1 cycle after read_data_valid or timeout.
// Backpressure: requesters hold req until ack; requests stay pending while a read is outstanding.
module register_file_arbiter #(
  parameter int  DATA_WIDTH          = 8,
  parameter int  REGISTER_FILE_DEPTH = 16,
  parameter int  TIMEOUT_CYCLES      = 15,
  localparam int AW                  = $clog2(REGISTER_FILE_DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [1:0]              req,
  input  logic [1:0]              req_write,
  input  logic [2*AW-1:0]         req_address,
  input  logic [2*DATA_WIDTH-1:0] req_write_data,
  output logic [1:0]              ack,
  output logic [1:0]              rd_valid,
  output logic [1:0]              rd_error,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic [AW-1:0]           register_file_address,
  output logic                    register_file_write_en,
  output logic [DATA_WIDTH-1:0]   register_file_write_data,
  output logic                    register_file_read_en,
  input  logic                    register_file_read_data_valid,
  input  logic [DATA_WIDTH-1:0]   register_file_read_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_READ} state_t;

  // Last WAIT_READ count value before the read is abandoned with an error.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t                r_state, w_state_nxt;
  logic                  r_last_grant, w_last_grant_nxt;
  logic                  r_grant, w_grant_nxt;       // owner of the in-flight transaction
  logic                  r_is_write, w_is_write_nxt;
  logic [7:0]            r_wait_cnt, w_wait_cnt_nxt;
  logic                  w_pick;
  logic [1:0]            w_owner_vec;

  logic [1:0]            r_ack, w_ack_nxt;
  logic [1:0]            r_rd_valid, w_rd_valid_nxt;
  logic [1:0]            r_rd_error, w_rd_error_nxt;
  logic [DATA_WIDTH-1:0] r_rd_data, w_rd_data_nxt;
  logic [AW-1:0]         r_rf_addr, w_rf_addr_nxt;
  logic                  r_rf_we, w_rf_we_nxt;
  logic [DATA_WIDTH-1:0] r_rf_wdata, w_rf_wdata_nxt;
  logic                  r_rf_re, w_rf_re_nxt;

  assign ack                      = r_ack;
  assign rd_valid                 = r_rd_valid;
  assign rd_error                 = r_rd_error;
  assign rd_data                  = r_rd_data;
  assign register_file_address    = r_rf_addr;
  assign register_file_write_en   = r_rf_we;
  assign register_file_write_data = r_rf_wdata;
  assign register_file_read_en    = r_rf_re;

  assign w_owner_vec = r_grant ? 2'b10 : 2'b01;

  // Next-state and next-output logic; every output is a one-cycle pulse so defaults are zero.
  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    w_grant_nxt      = r_grant;
    w_is_write_nxt   = r_is_write;
    w_wait_cnt_nxt   = r_wait_cnt;
    w_pick           = 1'b0;
    w_ack_nxt        = 2'b00;
    w_rd_valid_nxt   = 2'b00;
    w_rd_error_nxt   = 2'b00;
    w_rd_data_nxt    = '0;
    w_rf_addr_nxt    = '0;
    w_rf_we_nxt      = 1'b0;
    w_rf_wdata_nxt   = '0;
    w_rf_re_nxt      = 1'b0;
    case (r_state)
      IDLE: begin
        if (req != 2'b00) begin
          // On a tie the requester that did not win last time goes next.
          w_pick           = (req == 2'b11) ? ~r_last_grant : req[1];
          w_grant_nxt      = w_pick;
          w_last_grant_nxt = w_pick;
          w_is_write_nxt   = req_write[w_pick];
          w_ack_nxt        = w_pick ? 2'b10 : 2'b01;
          w_rf_addr_nxt    = w_pick ? req_address[AW +: AW] : req_address[0 +: AW];
          if (req_write[w_pick]) begin
            w_rf_we_nxt    = 1'b1;
            w_rf_wdata_nxt = w_pick ? req_write_data[DATA_WIDTH +: DATA_WIDTH]
                                    : req_write_data[0 +: DATA_WIDTH];
          end else begin
            w_rf_re_nxt    = 1'b1;
          end
          w_state_nxt      = ISSUE;
        end
      end
      ISSUE: begin
        w_wait_cnt_nxt = '0;
        w_state_nxt    = r_is_write ? IDLE : WAIT_READ;
      end
      WAIT_READ: begin
        if (register_file_read_data_valid) begin
          w_rd_valid_nxt = w_owner_vec;
          w_rd_data_nxt  = register_file_read_data;
          w_state_nxt    = IDLE;
        end else if (r_wait_cnt == CNT_LAST) begin
          w_rd_valid_nxt = w_owner_vec;
          w_rd_error_nxt = w_owner_vec;
          w_state_nxt    = IDLE;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + 8'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, bookkeeping and registered outputs; reset drops any in-flight transaction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_is_write   <= 1'b0;
      r_wait_cnt   <= '0;
      r_ack        <= 2'b00;
      r_rd_valid   <= 2'b00;
      r_rd_error   <= 2'b00;
      r_rd_data    <= '0;
      r_rf_addr    <= '0;
      r_rf_we      <= 1'b0;
      r_rf_wdata   <= '0;
      r_rf_re      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_grant      <= w_grant_nxt;
      r_is_write   <= w_is_write_nxt;
      r_wait_cnt   <= w_wait_cnt_nxt;
      r_ack        <= w_ack_nxt;
      r_rd_valid   <= w_rd_valid_nxt;
      r_rd_error   <= w_rd_error_nxt;
      r_rd_data    <= w_rd_data_nxt;
      r_rf_addr    <= w_rf_addr_nxt;
      r_rf_we      <= w_rf_we_nxt;
      r_rf_wdata   <= w_rf_wdata_nxt;
      r_rf_re      <= w_rf_re_nxt;
    end
  end

endmodule

// File: tb/tb_register_file_arbiter.sv
// Bench for register_file_arbiter: scoreboard of expected issues and read completions.
// Latency: inputs driven and outputs sampled 1ns after each rising edge.
// Backpressure: requesters hold req until their ack is observed.
`timescale 1ns/1ps
module tb_register_file_arbiter;
  localparam int DW = 8;
  localparam int AW = 4;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [1:0]      req, req_write;
  logic [2*AW-1:0] req_address;
  logic [2*DW-1:0] req_write_data;
  logic [1:0]      ack, rd_valid, rd_error;
  logic [DW-1:0]   rd_data, rf_wdata, rf_rdata;
  logic [AW-1:0]   rf_addr;
  logic            rf_we, rf_re, rf_rvalid;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [1:0]    ack;
    logic          we;
    logic          re;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } iss_t;

  typedef struct packed {
    logic [1:0]    vld;
    logic [1:0]    err;
    logic [DW-1:0] data;
  } rd_t;

  iss_t q_iss[$];
  rd_t  q_rd[$];

  always #5 clk = ~clk;

  register_file_arbiter #(.DATA_WIDTH(DW), .REGISTER_FILE_DEPTH(16), .TIMEOUT_CYCLES(15)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_write(req_write),
    .req_address(req_address), .req_write_data(req_write_data),
    .ack(ack), .rd_valid(rd_valid), .rd_error(rd_error), .rd_data(rd_data),
    .register_file_address(rf_addr), .register_file_write_en(rf_we),
    .register_file_write_data(rf_wdata), .register_file_read_en(rf_re),
    .register_file_read_data_valid(rf_rvalid), .register_file_read_data(rf_rdata)
  );

  // Structural invariants checked every cycle outside reset.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      total++;
      if (!$onehot0(ack) || !$onehot0(rd_valid) || (rf_we && rf_re) || ((rd_error & ~rd_valid) != 2'b00)) begin
        bad++;
        $display("FAIL invariant: ack=%b rd_valid=%b rd_error=%b we=%b re=%b", ack, rd_valid, rd_error, rf_we, rf_re);
      end
    end
  end

  function automatic iss_t obs_iss();
    return {ack, rf_we, rf_re, rf_addr, rf_wdata};
  endfunction

  function automatic rd_t obs_rd();
    return {rd_valid, rd_error, rd_data};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[k]                  = 1'b1;
    req_write[k]            = we;
    req_address[k*AW +: AW] = a;
    req_write_data[k*DW +: DW] = d;
  endtask

  task automatic push_iss(input int k, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    iss_t e;
    e.ack   = (k == 1) ? 2'b10 : 2'b01;
    e.we    = we;
    e.re    = ~we;
    e.addr  = a;
    e.wdata = we ? d : '0;
    q_iss.push_back(e);
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (ack == 2'b00 && n < 20);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req = '0; req_write = '0; req_address = '0; req_write_data = '0;
    rf_rvalid = 1'b0; rf_rdata = '0;
    tick(); tick();
    total++;
    if ({ack, rd_valid, rd_error, rd_data, rf_addr, rf_we, rf_wdata, rf_re} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got ack=%b rdv=%b err=%b data=%h addr=%h we=%b wd=%h re=%b, want all 0",
               ack, rd_valid, rd_error, rd_data, rf_addr, rf_we, rf_wdata, rf_re);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    int n; iss_t e;
    set_req(0, 1'b1, 4'h3, 8'hA5); push_iss(0, 1'b1, 4'h3, 8'hA5);
    wait_ack(n);
    total++; if (n != 1) begin bad++; $display("FAIL wr_latency: got %0d want 1", n); end
    e = q_iss.pop_front();
    total++; if (obs_iss() !== e) begin bad++; $display("FAIL wr_issue: got %h want %h", obs_iss(), e); end
    req[0] = 1'b0;
    tick();
    total++;
    if ({ack, rf_we, rf_re, rf_addr, rf_wdata} !== '0) begin
      bad++; $display("FAIL wr_clear: got %h want 0", obs_iss());
    end
  endtask

  task automatic test_read();
    int n; iss_t e; rd_t r;
    set_req(1, 1'b0, 4'h7, 8'h00); push_iss(1, 1'b0, 4'h7, 8'h00);
    wait_ack(n);
    total++; if (n != 1) begin bad++; $display("FAIL rd_latency: got %0d want 1", n); end
    e = q_iss.pop_front();
    total++; if (obs_iss() !== e) begin bad++; $display("FAIL rd_issue: got %h want %h", obs_iss(), e); end
    req[1] = 1'b0;
    tick();
    rf_rvalid = 1'b1; rf_rdata = 8'h3C; q_rd.push_back({2'b10, 2'b00, 8'h3C});
    tick();
    rf_rvalid = 1'b0;
    r = q_rd.pop_front();
    total++; if (obs_rd() !== r) begin bad++; $display("FAIL rd_complete: got %h want %h", obs_rd(), r); end
    tick();
  endtask

  task automatic test_fairness();
    int cnt = 0; int gap = 0; iss_t e;
    for (int i = 0; i < 6; i++) push_iss(i % 2, 1'b1, (i % 2) ? 4'h2 : 4'h1, (i % 2) ? 8'h22 : 8'h11);
    set_req(0, 1'b1, 4'h1, 8'h11);
    set_req(1, 1'b1, 4'h2, 8'h22);
    for (int c = 0; c < 30 && cnt < 6; c++) begin
      tick();
      gap++;
      if (ack != 2'b00) begin
        e = q_iss.pop_front();
        total++; if (obs_iss() !== e) begin bad++; $display("FAIL fair_order #%0d: got %h want %h", cnt, obs_iss(), e); end
        total++; if (gap != ((cnt == 0) ? 1 : 2)) begin bad++; $display("FAIL fair_gap #%0d: got %0d want %0d", cnt, gap, (cnt == 0) ? 1 : 2); end
        gap = 0;
        cnt++;
        if (cnt == 6) req = 2'b00;
      end
    end
    total++; if (cnt != 6) begin bad++; $display("FAIL fair_count: got %0d want 6", cnt); req = 2'b00; end
    tick();
  endtask

  task automatic test_timeout();
    int n; iss_t e; rd_t r; logic [1:0] seen;
    set_req(0, 1'b0, 4'h5, 8'h00); push_iss(0, 1'b0, 4'h5, 8'h00);
    wait_ack(n);
    e = q_iss.pop_front();
    total++; if (obs_iss() !== e) begin bad++; $display("FAIL to_issue: got %h want %h", obs_iss(), e); end
    req[0] = 1'b0;
    q_rd.push_back({2'b01, 2'b01, 8'h00});
    n = 0;
    do begin tick(); n++; end while (rd_valid == 2'b00 && n < 30);
    total++; if (n != 16) begin bad++; $display("FAIL to_latency: got %0d want 16", n); end
    r = q_rd.pop_front();
    total++; if (obs_rd() !== r) begin bad++; $display("FAIL to_complete: got %h want %h", obs_rd(), r); end
    rf_rvalid = 1'b1; rf_rdata = 8'hFF;
    tick();
    rf_rvalid = 1'b0;
    seen = rd_valid;
    repeat (3) begin tick(); seen |= rd_valid; end
    total++; if (seen != 2'b00) begin bad++; $display("FAIL to_late_valid: got rd_valid=%b want 00", seen); end
  endtask

  task automatic test_valid_at_terminal();
    int n; iss_t e; rd_t r; logic [1:0] seen = 2'b00;
    set_req(1, 1'b0, 4'h6, 8'h00); push_iss(1, 1'b0, 4'h6, 8'h00);
    wait_ack(n);
    e = q_iss.pop_front();
    total++; if (obs_iss() !== e) begin bad++; $display("FAIL term_issue: got %h want %h", obs_iss(), e); end
    req[1] = 1'b0;
    repeat (15) begin tick(); seen |= rd_valid; end
    total++; if (seen != 2'b00) begin bad++; $display("FAIL term_early: got rd_valid=%b want 00", seen); end
    rf_rvalid = 1'b1; rf_rdata = 8'h5A; q_rd.push_back({2'b10, 2'b00, 8'h5A});
    tick();
    rf_rvalid = 1'b0;
    r = q_rd.pop_front();
    total++; if (obs_rd() !== r) begin bad++; $display("FAIL term_complete: got %h want %h", obs_rd(), r); end
    tick();
  endtask

  task automatic test_mid_wait();
    int n; iss_t e; rd_t r; logic [1:0] seen = 2'b00;
    set_req(0, 1'b0, 4'h9, 8'h00); push_iss(0, 1'b0, 4'h9, 8'h00);
    wait_ack(n);
    e = q_iss.pop_front();
    total++; if (obs_iss() !== e) begin bad++; $display("FAIL mid_issue0: got %h want %h", obs_iss(), e); end
    req[0] = 1'b0;
    set_req(1, 1'b1, 4'h4, 8'h77); push_iss(1, 1'b1, 4'h4, 8'h77);
    repeat (3) begin tick(); seen |= ack; end
    total++; if (seen != 2'b00) begin bad++; $display("FAIL mid_early_ack: got %b want 00", seen); end
    rf_rvalid = 1'b1; rf_rdata = 8'h42; q_rd.push_back({2'b01, 2'b00, 8'h42});
    tick();
    rf_rvalid = 1'b0;
    r = q_rd.pop_front();
    total++; if (obs_rd() !== r) begin bad++; $display("FAIL mid_complete: got %h want %h", obs_rd(), r); end
    total++; if (ack != 2'b00) begin bad++; $display("FAIL mid_ack_with_rdv: got %b want 00", ack); end
    tick();
    e = q_iss.pop_front();
    total++; if (obs_iss() !== e) begin bad++; $display("FAIL mid_issue1: got %h want %h", obs_iss(), e); end
    req[1] = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_op();
    int n; iss_t e; logic [1:0] seen;
    // Reset while a write is being issued: strobes drop without waiting for a clock.
    set_req(0, 1'b1, 4'h8, 8'hC3);
    tick();
    total++; if (ack != 2'b01) begin bad++; $display("FAIL rst_pre_ack: got %b want 01", ack); end
    #2 reset_n = 1'b0; req = 2'b00;
    #1;
    total++; if ({ack, rf_we, rf_re, rf_addr, rf_wdata} !== '0) begin bad++; $display("FAIL rst_issue_clear: got %h want 0", obs_iss()); end
    @(posedge clk); #1 reset_n = 1'b1;
    tick();
    // Reset while a read from requester 0 is outstanding.
    set_req(0, 1'b0, 4'h2, 8'h00); push_iss(0, 1'b0, 4'h2, 8'h00);
    wait_ack(n);
    e = q_iss.pop_front();
    total++; if (obs_iss() !== e) begin bad++; $display("FAIL rst_rd_issue: got %h want %h", obs_iss(), e); end
    req[0] = 1'b0;
    tick(); tick();
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({ack, rd_valid, rd_error, rd_data, rf_addr, rf_we, rf_wdata, rf_re} !== '0) begin
      bad++; $display("FAIL rst_wait_clear: got ack=%b rdv=%b re=%b we=%b want all 0", ack, rd_valid, rf_re, rf_we);
    end
    @(posedge clk); #1 reset_n = 1'b1;
    rf_rvalid = 1'b1; rf_rdata = 8'h99;
    tick();
    rf_rvalid = 1'b0;
    seen = rd_valid;
    repeat (3) begin tick(); seen |= rd_valid; end
    total++; if (seen != 2'b00) begin bad++; $display("FAIL rst_no_rdv: got %b want 00", seen); end
    // Tie after reset: requester 0 first even though it won the last grant before reset.
    push_iss(0, 1'b1, 4'hA, 8'h11); push_iss(1, 1'b1, 4'hB, 8'h22);
    set_req(0, 1'b1, 4'hA, 8'h11); set_req(1, 1'b1, 4'hB, 8'h22);
    wait_ack(n);
    e = q_iss.pop_front();
    total++; if (obs_iss() !== e) begin bad++; $display("FAIL rst_tie_first: got %h want %h", obs_iss(), e); end
    req[0] = 1'b0;
    wait_ack(n);
    e = q_iss.pop_front();
    total++; if (obs_iss() !== e) begin bad++; $display("FAIL rst_tie_second: got %h want %h", obs_iss(), e); end
    req[1] = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read();
    test_fairness();
    test_timeout();
    test_valid_at_terminal();
    test_mid_wait();
    test_reset_mid_op();
    total++;
    if (q_iss.size() != 0 || q_rd.size() != 0) begin
      bad++; $display("FAIL scoreboard_drain: got iss=%0d rd=%0d left want 0", q_iss.size(), q_rd.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
